// File: rtl/ad98xx_spi_seq_pkg.sv
// rtl/ad98xx_spi_seq_pkg.sv - states, default parameters and count-width helper for ad98xx_spi_seq
package ad98xx_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP, DONE} state_t;

  localparam int DEF_WORD_W    = 16;
  localparam int DEF_MAX_WORDS = 3;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_FSYNC_GAP = 2;

  function automatic int count_w(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/ad98xx_spi_seq_tick.sv
// rtl/ad98xx_spi_seq_tick.sv - phase prescaler; tick marks the last cycle of a phase of len cycles
module ad98xx_tick
  import ad98xx_pkg::*;
#(
  parameter int LEN_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [LEN_W-1:0] len,
  output logic             tick
);

  logic [LEN_W-1:0] cnt;

  // Reloaded on every phase change so no phase is ever shortened or stretched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= len - LEN_W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - LEN_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/ad98xx_spi_seq.sv
// rtl/ad98xx_spi_seq.sv - AD98xx serial word sequencer (fsync/sclk/sdata, MSB first)
// Optional auto-repeat input repeat_frame when AD98XX_REPEAT_EN is defined.
module ad98xx_spi_seq
  import ad98xx_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int FSYNC_GAP = DEF_FSYNC_GAP
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go,
  input  logic [WORD_W*MAX_WORDS-1:0]   words,
  input  logic [count_w(MAX_WORDS)-1:0] num_words,
`ifdef AD98XX_REPEAT_EN
  input  logic                          repeat_frame,
`endif
  output logic                          good_to_reset_go,
  output logic                          send_complete,
  output logic                          busy,
  output logic                          fsync,
  output logic                          sclk,
  output logic                          sdata
);

  localparam int CW      = count_w(MAX_WORDS);
  localparam int BW      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int LEN_MAX = (CLK_DIV > FSYNC_GAP) ? CLK_DIV : FSYNC_GAP;
  localparam int LEN_W   = $clog2(LEN_MAX + 1);

  state_t                  state, state_n;
  logic [BW-1:0]           bit_idx, bit_n;
  logic [CW-1:0]           word_idx, word_n, count_lat, count_in;
  logic [WORD_W*MAX_WORDS-1:0] words_lat, words_src;
  logic [WORD_W-1:0]       cur_word;
  logic [LEN_W-1:0]        len;
  logic                    tick, restart, accept, rpt;

`ifdef AD98XX_REPEAT_EN
  assign rpt = repeat_frame;
`else
  assign rpt = 1'b0;
`endif

  assign count_in  = (num_words > CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : num_words;
  assign accept    = (state == IDLE) && go;
  assign restart   = (state_n != state);
  assign words_src = accept ? words : words_lat;
  assign cur_word  = words_src[int'(word_n)*WORD_W +: WORD_W];

  ad98xx_tick #(.LEN_W(LEN_W)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .len     (len),
    .tick    (tick)
  );

  always_comb begin
    state_n = state;
    bit_n   = bit_idx;
    word_n  = word_idx;
    len     = LEN_W'(CLK_DIV);
    case (state)
      IDLE: begin
        if (go) begin
          word_n = '0;
          bit_n  = BW'(WORD_W - 1);
          // An empty frame spends one quiet GAP cycle so completion follows the acknowledge.
          if (count_in == '0) begin
            state_n = GAP;
            len     = LEN_W'(1);
          end else begin
            state_n = SETUP;
          end
        end
      end
      SETUP:    if (tick) state_n = SHIFT_HI;
      SHIFT_HI: if (tick) state_n = SHIFT_LO;
      SHIFT_LO: begin
        if (tick) begin
          if (bit_idx == '0) begin
            state_n = GAP;
            len     = LEN_W'(FSYNC_GAP);
          end else begin
            bit_n   = bit_idx - BW'(1);
            state_n = SHIFT_HI;
          end
        end
      end
      GAP: begin
        if (tick) begin
          bit_n = BW'(WORD_W - 1);
          if ((word_idx + CW'(1)) < count_lat) begin
            word_n  = word_idx + CW'(1);
            state_n = SETUP;
          end else if (rpt && (count_lat != '0)) begin
            word_n  = '0;
            state_n = SETUP;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bit_idx          <= '0;
      word_idx         <= '0;
      count_lat        <= '0;
      words_lat        <= '0;
      good_to_reset_go <= 1'b0;
      send_complete    <= 1'b0;
      busy             <= 1'b0;
      fsync            <= 1'b1;
      sclk             <= 1'b1;
      sdata            <= 1'b0;
    end else begin
      state    <= state_n;
      bit_idx  <= bit_n;
      word_idx <= word_n;
      if (accept) begin
        count_lat <= count_in;
        words_lat <= words;
      end
      good_to_reset_go <= accept;
      send_complete    <= (state_n == DONE);
      busy             <= (state_n != IDLE);
      fsync            <= !(state_n inside {SETUP, SHIFT_HI, SHIFT_LO});
      sclk             <= (state_n != SHIFT_LO);
      sdata            <= (state_n inside {SETUP, SHIFT_HI, SHIFT_LO}) && cur_word[bit_n];
    end
  end

endmodule

// File: tb/tb_ad98xx_spi_seq.sv
// tb/tb_ad98xx_spi_seq.sv - scoreboard bench for ad98xx_spi_seq (default and 28-bit/CLK_DIV=1 instances)
module tb_ad98xx_spi_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        go0, ack0, sc0, busy0, fs0, sclk0, sd0;
  logic [47:0] words0;
  logic [1:0]  num0;
  logic        go1, ack1, sc1, busy1, fs1, sclk1, sd1;
  logic [55:0] words1;
  logic [1:0]  num1;
`ifdef AD98XX_REPEAT_EN
  logic        rpt0;
  int          rpt_off_k;
`endif

  ad98xx_spi_seq u_dut0 (
    .clk(clk), .rst(rst), .go(go0), .words(words0), .num_words(num0),
`ifdef AD98XX_REPEAT_EN
    .repeat_frame(rpt0),
`endif
    .good_to_reset_go(ack0), .send_complete(sc0), .busy(busy0),
    .fsync(fs0), .sclk(sclk0), .sdata(sd0)
  );

  ad98xx_spi_seq #(.WORD_W(28), .MAX_WORDS(2), .CLK_DIV(1), .FSYNC_GAP(2)) u_dut1 (
    .clk(clk), .rst(rst), .go(go1), .words(words1), .num_words(num1),
`ifdef AD98XX_REPEAT_EN
    .repeat_frame(1'b0),
`endif
    .good_to_reset_go(ack1), .send_complete(sc1), .busy(busy1),
    .fsync(fs1), .sclk(sclk1), .sdata(sd1)
  );

  int vectors = 0;
  int fails   = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Serial capture: bits on sclk falls, compared against the queue when fsync rises.
  logic [31:0] m0_sh, m1_sh;
  int          m0_bits, m0_len, m1_bits, m1_len;
  logic        m0_ps, m0_pf, m1_ps, m1_pf;

  always @(negedge clk) begin
    if (rst) begin
      m0_sh = '0; m0_bits = 0; m0_len = 0; m0_ps = 1'b1; m0_pf = 1'b1;
    end else begin
      if (!fs0) m0_len++;
      if (m0_ps && !sclk0) begin m0_sh = {m0_sh[30:0], sd0}; m0_bits++; end
      if (!m0_pf && fs0) begin
        chk("w0_pending", 32'(exp0_q.size() != 0), 1);
        if (exp0_q.size() != 0) chk("w0_data", m0_sh, exp0_q.pop_front());
        chk("w0_bits", m0_bits, 16);
        chk("w0_window", m0_len, 66);
        m0_sh = '0; m0_bits = 0; m0_len = 0;
      end
      m0_ps = sclk0; m0_pf = fs0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      m1_sh = '0; m1_bits = 0; m1_len = 0; m1_ps = 1'b1; m1_pf = 1'b1;
    end else begin
      if (!fs1) m1_len++;
      if (m1_ps && !sclk1) begin m1_sh = {m1_sh[30:0], sd1}; m1_bits++; end
      if (!m1_pf && fs1) begin
        chk("w1_pending", 32'(exp1_q.size() != 0), 1);
        if (exp1_q.size() != 0) chk("w1_data", m1_sh, exp1_q.pop_front());
        chk("w1_bits", m1_bits, 28);
        chk("w1_window", m1_len, 57);
        m1_sh = '0; m1_bits = 0; m1_len = 0;
      end
      m1_ps = sclk1; m1_pf = fs1;
    end
  end

  int n_ack, k_ack, k_sc, k_sc2, n_sc, n_lo, busy_after;

  task automatic watch0(input int len, input int drop_at, input int p_on, input int p_off,
                        input logic exp_fs1);
    n_ack = 0; k_ack = 0; k_sc = 0; k_sc2 = 0; n_sc = 0; n_lo = 0; busy_after = 1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("ack_first", ack0, 1);
        chk("busy_first", busy0, 1);
        chk("fsync_first", fs0, exp_fs1);
      end
      if (ack0) begin n_ack++; k_ack = k; end
      if (sc0) begin n_sc++; if (k_sc == 0) k_sc = k; k_sc2 = k; end
      if (!fs0) n_lo++;
      if (k_sc != 0 && k == k_sc + 1) busy_after = busy0;
      if (k == drop_at) go0 = 1'b0;
      if (k == p_on) go0 = 1'b1;
      if (k == p_off) go0 = 1'b0;
`ifdef AD98XX_REPEAT_EN
      if (k == rpt_off_k) rpt0 = 1'b0;
`endif
    end
  endtask

  task automatic watch1(input int len);
    n_ack = 0; k_sc = 0; n_sc = 0; n_lo = 0; busy_after = 1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("d1_ack_first", ack1, 1);
        chk("d1_fsync_first", fs1, 0);
        go1 = 1'b0;
      end
      if (ack1) n_ack++;
      if (sc1) begin n_sc++; if (k_sc == 0) k_sc = k; end
      if (!fs1) n_lo++;
      if (k_sc != 0 && k == k_sc + 1) busy_after = busy1;
    end
  endtask

  initial begin
    rst = 1'b1;
    go0 = 1'b0; words0 = '0; num0 = '0;
    go1 = 1'b0; words1 = '0; num1 = '0;
`ifdef AD98XX_REPEAT_EN
    rpt0 = 1'b0; rpt_off_k = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_fsync", fs0, 1);
    chk("rst_sclk", sclk0, 1);
    chk("rst_sdata", sd0, 0);
    chk("rst_ack", ack0, 0);
    chk("rst_sc", sc0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst1_fsync", fs1, 1);
    chk("rst1_busy", busy1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Three default words, with go pulsed again mid-frame.
    words0 = {16'hBAAD, 16'hEAAD, 16'hAAAD}; num0 = 2'd3; go0 = 1'b1;
    exp0_q.push_back(32'hAAAD); exp0_q.push_back(32'hEAAD); exp0_q.push_back(32'hBAAD);
    watch0(300, 1, 100, 104, 1'b0);
    chk("a_n_ack", n_ack, 1);
    chk("a_sc_cycle", k_sc, 205);
    chk("a_n_sc", n_sc, 1);
    chk("a_fsync_low", n_lo, 198);
    chk("a_busy_fall", busy_after, 0);
    chk("a_q_empty", exp0_q.size(), 0);

    // Empty frame.
    num0 = 2'd0; go0 = 1'b1;
    watch0(10, 1, 0, 0, 1'b1);
    chk("z_n_ack", n_ack, 1);
    chk("z_sc_cycle", k_sc, 2);
    chk("z_n_sc", n_sc, 1);
    chk("z_fsync_low", n_lo, 0);

    // go held through DONE re-arms immediately.
    words0 = {32'h0, 16'h1234}; num0 = 2'd1; go0 = 1'b1;
    exp0_q.push_back(32'h1234); exp0_q.push_back(32'h1234);
    watch0(160, 71, 0, 0, 1'b0);
    chk("h_n_ack", n_ack, 2);
    chk("h_ack2_cycle", k_ack, 71);
    chk("h_sc1_cycle", k_sc, 69);
    chk("h_sc2_cycle", k_sc2, 139);
    chk("h_busy_fall", busy_after, 0);
    chk("h_q_empty", exp0_q.size(), 0);

    // Reset during word 1, bit 5.
    words0 = {16'hBAAD, 16'hEAAD, 16'hAAAD}; num0 = 2'd3; go0 = 1'b1;
    exp0_q.push_back(32'hAAAD); exp0_q.push_back(32'hEAAD); exp0_q.push_back(32'hBAAD);
    for (int k = 1; k <= 112; k++) begin
      @(negedge clk);
      if (k == 1) go0 = 1'b0;
    end
    chk("r_pre_sclk", sclk0, 1);
    chk("r_pre_fsync", fs0, 0);
    chk("r_pre_sdata", sd0, 1);
    #1 rst = 1'b1;
    #1;
    chk("r_fsync", fs0, 1);
    chk("r_sclk", sclk0, 1);
    chk("r_sdata", sd0, 0);
    chk("r_busy", busy0, 0);
    exp0_q.delete();
    n_sc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (sc0) n_sc++;
    end
    chk("r_no_sc", n_sc, 0);
    rst = 1'b0;
    @(negedge clk);

    words0 = {16'h0, 16'hC3A5, 16'h5A3C}; num0 = 2'd2; go0 = 1'b1;
    exp0_q.push_back(32'h5A3C); exp0_q.push_back(32'hC3A5);
    watch0(160, 1, 0, 0, 1'b0);
    chk("e_n_ack", n_ack, 1);
    chk("e_sc_cycle", k_sc, 137);
    chk("e_fsync_low", n_lo, 132);
    chk("e_q_empty", exp0_q.size(), 0);

    // 28-bit instance, single word.
    words1 = {28'h0, 28'h9A5C3E1}; num1 = 2'd1; go1 = 1'b1;
    exp1_q.push_back(32'h9A5C3E1);
    watch1(80);
    chk("f_n_ack", n_ack, 1);
    chk("f_sc_cycle", k_sc, 60);
    chk("f_busy_fall", busy_after, 0);
    chk("f_fsync_low", n_lo, 57);
    chk("f_q_empty", exp1_q.size(), 0);

    // Count above MAX_WORDS is clamped.
    words1 = {28'h7654321, 28'h0FEDCBA}; num1 = 2'd3; go1 = 1'b1;
    exp1_q.push_back(32'h0FEDCBA); exp1_q.push_back(32'h7654321);
    watch1(150);
    chk("g_n_sc", n_sc, 1);
    chk("g_sc_cycle", k_sc, 119);
    chk("g_fsync_low", n_lo, 114);
    chk("g_q_empty", exp1_q.size(), 0);

`ifdef AD98XX_REPEAT_EN
    // Two-word loop for three passes; repeat dropped during the third.
    words0 = {16'h0, 16'hC3A5, 16'h5A3C}; num0 = 2'd2; rpt0 = 1'b1; rpt_off_k = 282;
    for (int p = 0; p < 3; p++) begin
      exp0_q.push_back(32'h5A3C); exp0_q.push_back(32'hC3A5);
    end
    go0 = 1'b1;
    watch0(450, 1, 0, 0, 1'b0);
    chk("p_n_ack", n_ack, 1);
    chk("p_n_sc", n_sc, 1);
    chk("p_sc_cycle", k_sc, 409);
    chk("p_fsync_low", n_lo, 396);
    chk("p_q_empty", exp0_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
